cnt_ud_mod: RTL and testbench

Parametrised synchronous up/down modulus counter, built as the successor to the fixed 3-bit up/down counters in the counter library. It generalises width and modulus and adds:
- parallel load
- count enable
- wrap or saturate mode
- a terminal-count flag
- a registered rollover pulse

It is used as a general event/divider counter; the tc output allows cascading into wider counters.

---
 rtl/cnt_ud_mod.sv | 75 +++++++
 tb/tb_cnt_ud_mod.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cnt_ud_mod.sv
// Parametrised synchronous up/down modulus counter with parallel load, enable,
// wrap/saturate ends, combinational terminal count and registered rollover pulse.
module cnt_ud_mod #(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             M,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             ovf
);

  localparam int               MAX_INT = MODULUS - 1;
  localparam logic [WIDTH-1:0] MAX_Q   = MAX_INT[WIDTH-1:0];
  localparam logic [WIDTH:0]   MOD_EXT = MODULUS[WIDTH:0];
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam bit               SAT     = (SATURATE != 0);

  logic             at_top;
  logic             at_bot;
  logic             in_range;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] up_val;
  logic [WIDTH-1:0] down_val;
  logic [WIDTH-1:0] count_val;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] t_bits;
  logic             ovf_next;

  // Extra MSB on the range compares so MODULUS == 2**WIDTH still works.
  assign at_top   = (q == MAX_Q);
  assign at_bot   = (q == ZERO);
  assign in_range = ({1'b0, q} < MOD_EXT);

  assign tc = en & ((~M & at_top) | (M & at_bot));
  assign qb = ~q;

  assign load_val  = ({1'b0, d} >= MOD_EXT) ? MAX_Q : d;
  assign up_val    = at_top ? (SAT ? MAX_Q : ZERO) : (q + ONE);
  assign down_val  = at_bot ? (SAT ? ZERO : MAX_Q) : (q - ONE);
  assign count_val = in_range ? (M ? down_val : up_val) : ZERO;

  always_comb begin
    q_next   = q;
    ovf_next = 1'b0;
    if (ld) begin
      q_next = load_val;
    end else if (en) begin
      q_next   = count_val;
      ovf_next = tc;
    end
  end

  // Per-bit toggle enables, in the style of the T flip-flop library counters.
  assign t_bits = q ^ q_next;

  always_ff @(posedge clk) begin
    if (res) begin
      q   <= '0;
      ovf <= 1'b0;
    end else begin
      q   <= q ^ t_bits;
      ovf <= ovf_next;
    end
  end

endmodule

// File: tb/tb_cnt_ud_mod.sv
// Scoreboard bench for cnt_ud_mod: wrap and saturate modulo-6 counters plus a
// two-stage decade cascade, all driven by shared directed and random stimulus.
module tb_cnt_ud_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res = 1'b1;
  logic       ld  = 1'b0;
  logic       en  = 1'b0;
  logic       m   = 1'b0;
  logic [2:0] d   = 3'd0;

  logic [2:0] q_w, qb_w, q_s, qb_s;
  logic       tc_w, ovf_w, tc_s, ovf_s;
  logic [3:0] lo_q, lo_qb, hi_q, hi_qb;
  logic       lo_tc, lo_ovf, hi_tc, hi_ovf;

  cnt_ud_mod #(.WIDTH(3), .MODULUS(6), .SATURATE(0)) dut_wrap (
    .clk(clk), .res(res), .en(en), .M(m), .ld(ld), .d(d),
    .q(q_w), .qb(qb_w), .tc(tc_w), .ovf(ovf_w)
  );

  cnt_ud_mod #(.WIDTH(3), .MODULUS(6), .SATURATE(1)) dut_sat (
    .clk(clk), .res(res), .en(en), .M(m), .ld(ld), .d(d),
    .q(q_s), .qb(qb_s), .tc(tc_s), .ovf(ovf_s)
  );

  cnt_ud_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_lo (
    .clk(clk), .res(res), .en(en), .M(m), .ld(1'b0), .d(4'd0),
    .q(lo_q), .qb(lo_qb), .tc(lo_tc), .ovf(lo_ovf)
  );

  cnt_ud_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_hi (
    .clk(clk), .res(res), .en(lo_tc), .M(m), .ld(1'b0), .d(4'd0),
    .q(hi_q), .qb(hi_qb), .tc(hi_tc), .ovf(hi_ovf)
  );

  typedef struct {
    int qw; int ovw; int tcw;
    int qs; int ovs; int tcs;
    int cas;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference state: plain integers, counting modulo 6 or clamped to 0..5.
  int mq_w = 0, mo_w = 0, mq_s = 0, mo_s = 0, mv_c = 0;

  function automatic void step(input int q, input bit sat, input bit r, input bit l,
                               input bit e, input bit mm, input int dv,
                               output int qn, output int on);
    int nxt;
    if (r) begin
      qn = 0; on = 0;
    end else if (l) begin
      qn = (dv > 5) ? 5 : dv; on = 0;
    end else if (e) begin
      nxt = mm ? q - 1 : q + 1;
      on  = (nxt < 0 || nxt > 5) ? 1 : 0;
      if (sat) qn = (nxt < 0) ? 0 : ((nxt > 5) ? 5 : nxt);
      else     qn = (nxt + 6) % 6;
    end else begin
      qn = q; on = 0;
    end
  endfunction

  function automatic int tc_of(input int q, input bit e, input bit mm);
    return (e && (mm ? (q == 0) : (q == 5))) ? 1 : 0;
  endfunction

  task automatic checkOutput(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  // Drives one cycle of inputs just after an edge, queues what the monitor
  // should see before the next edge, then advances the model across that edge.
  task automatic applyStimulus(input bit r, input bit l, input bit e, input bit mm, input int dv);
    exp_t x;
    int   a, b;
    res = r; ld = l; en = e; m = mm; d = dv[2:0];
    x.qw  = mq_w; x.ovw = mo_w; x.tcw = tc_of(mq_w, e, mm);
    x.qs  = mq_s; x.ovs = mo_s; x.tcs = tc_of(mq_s, e, mm);
    x.cas = mv_c;
    sb.push_back(x);
    step(mq_w, 1'b0, r, l, e, mm, dv, a, b); mq_w = a; mo_w = b;
    step(mq_s, 1'b1, r, l, e, mm, dv, a, b); mq_s = a; mo_s = b;
    if (r)      mv_c = 0;
    else if (e) mv_c = mm ? (mv_c + 99) % 100 : (mv_c + 1) % 100;
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checkOutput("wrap_q",   int'(q_w),   x.qw);
        checkOutput("wrap_qb",  int'(qb_w),  7 - x.qw);
        checkOutput("wrap_tc",  int'(tc_w),  x.tcw);
        checkOutput("wrap_ovf", int'(ovf_w), x.ovw);
        checkOutput("sat_q",    int'(q_s),   x.qs);
        checkOutput("sat_qb",   int'(qb_s),  7 - x.qs);
        checkOutput("sat_tc",   int'(tc_s),  x.tcs);
        checkOutput("sat_ovf",  int'(ovf_s), x.ovs);
        checkOutput("cascade",  int'(hi_q) * 10 + int'(lo_q), x.cas);
        checkOutput("lo_qb",    int'(lo_qb), 15 - int'(lo_q));
      end
    end
  end

  initial begin : stimulus
    // First edge under reset brings every counter to a known state.
    @(posedge clk);
    #1;
    mq_w = 0; mo_w = 0; mq_s = 0; mo_s = 0; mv_c = 0;

    $display("[TB] reset, then 25 up edges (wrap and cascade)");
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 25; i++) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] load 2 then wrap down");
    applyStimulus(0, 1, 0, 0, 2);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 0);

    $display("[TB] load 4, push past the top, step back down");
    applyStimulus(0, 1, 0, 0, 4);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0);

    $display("[TB] load clamp and priority");
    applyStimulus(0, 1, 0, 0, 7);
    applyStimulus(0, 1, 1, 0, 1);
    applyStimulus(1, 1, 0, 0, 3);
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] direction toggle and mid-count reset");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 7)));
    end
    applyStimulus(0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) checkOutput("drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
